// File: rtl/regfile_multiport.sv
// Parameterised multi-port register file: one write port, NUM_RD read ports.
// Each read port can forward a same-cycle write and can optionally register its output.

module regfile_rdport #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 32,
    parameter int SEL_W     = $clog2(DEPTH),
    parameter bit ZERO_LAST = 1,
    parameter bit BYPASS    = 1,
    parameter bit REG_RD    = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic                        wr_ok,
    input  logic [SEL_W-1:0]            wr_sel,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    input  logic [SEL_W-1:0]            rd_sel,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid
);
    localparam logic [SEL_W:0] LIM  = (SEL_W+1)'(DEPTH);
    localparam logic [SEL_W:0] LAST = (SEL_W+1)'(DEPTH-1);

    logic [WIDTH-1:0] eff;
    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    // An X select fails both tests below, so eff stays at 0 instead of going X.
    always_comb begin
        eff = '0;
        if (({1'b0, rd_sel} < LIM) && !(ZERO_LAST && ({1'b0, rd_sel} == LAST))) begin
            if (BYPASS && wr_ok && (wr_sel == rd_sel))
                eff = wr_data;
            else
                eff = mem[rd_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= rd_en;
            if (rd_en)
                data_q <= eff;
        end
    end

    // Combinational mode leaves the output flops unloaded so synthesis removes them.
    assign rd_data  = REG_RD ? data_q : eff;
    assign rd_valid = REG_RD ? vld_q  : 1'b1;
endmodule

module regfile_multiport #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 32,
    parameter int SEL_W     = $clog2(DEPTH),
    parameter int NUM_RD    = 2,
    parameter bit ZERO_LAST = 1,
    parameter bit BYPASS    = 1,
    parameter bit REG_RD    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [SEL_W-1:0]        wr_sel,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*SEL_W-1:0] rd_sel,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_valid
);
    localparam logic [SEL_W:0] LIM  = (SEL_W+1)'(DEPTH);
    localparam logic [SEL_W:0] LAST = (SEL_W+1)'(DEPTH-1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        wr_ok;

    // Out-of-range and hardwired-zero targets are dropped here, which also keeps them out of the bypass path.
    assign wr_ok = wr_en && ({1'b0, wr_sel} < LIM) && !(ZERO_LAST && ({1'b0, wr_sel} == LAST));

    always_ff @(posedge clk) begin
        if (reset)
            mem <= '0;
        else if (wr_ok)
            mem[wr_sel] <= wr_data;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rdport #(
            .WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W),
            .ZERO_LAST(ZERO_LAST), .BYPASS(BYPASS), .REG_RD(REG_RD)
        ) u_port (
            .clk     (clk),
            .reset   (reset),
            .mem     (mem),
            .wr_ok   (wr_ok),
            .wr_sel  (wr_sel),
            .wr_data (wr_data),
            .rd_en   (rd_en[i]),
            .rd_sel  (rd_sel[i*SEL_W +: SEL_W]),
            .rd_data (rd_data[i*WIDTH +: WIDTH]),
            .rd_valid(rd_valid[i])
        );
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: four configurations share one stimulus stream.
// a: default, b: ZERO_LAST=0/BYPASS=0, c: REG_RD=1, d: DEPTH=24.

module tb_regfile_multiport;
    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_sel;
    logic [63:0]  wr_data;
    logic [1:0]   rd_en;
    logic [9:0]   rd_sel;
    logic [127:0] rd_a, rd_b, rd_c, rd_d;
    logic [1:0]   vl_a, vl_b, vl_c, vl_d;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    regfile_multiport u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_a), .rd_valid(vl_a));
    regfile_multiport #(.ZERO_LAST(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_b), .rd_valid(vl_b));
    regfile_multiport #(.REG_RD(1)) u_c (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_c), .rd_valid(vl_c));
    regfile_multiport #(.DEPTH(24)) u_d (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_d), .rd_valid(vl_d));

    // Advance one clock and land 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_en = 2'b00; rd_sel = '0;
        tick();
        tick();
        reset = 1'b0;
        rd_sel = {5'd5, 5'd0};
        #1;
        checks++; if (rd_a !== 128'd0) begin fails++; $display("FAIL reset_a_sel0_5 got=%h exp=0", rd_a); end
        checks++; if (rd_b !== 128'd0) begin fails++; $display("FAIL reset_b_sel0_5 got=%h exp=0", rd_b); end
        checks++; if (rd_d !== 128'd0) begin fails++; $display("FAIL reset_d_sel0_5 got=%h exp=0", rd_d); end
        checks++; if (vl_a !== 2'b11) begin fails++; $display("FAIL reset_a_valid got=%b exp=11", vl_a); end
        checks++; if (vl_c !== 2'b00 || rd_c !== 128'd0) begin fails++; $display("FAIL reset_c_regs got=%b/%h exp=00/0", vl_c, rd_c); end
        rd_sel = {5'd30, 5'd30};
        #1;
        checks++; if (rd_a !== 128'd0) begin fails++; $display("FAIL reset_a_sel30 got=%h exp=0", rd_a); end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_sel = 5'd3;  wr_data = 64'd17;
        tick();
        wr_sel = 5'd12; wr_data = 64'd25;
        tick();
        wr_en = 1'b0;
        rd_sel = {5'd12, 5'd3};
        #1;
        checks++; if (rd_a !== {64'd25, 64'd17}) begin fails++; $display("FAIL wr_rd_a got=%h exp=%h", rd_a, {64'd25, 64'd17}); end
        checks++; if (rd_b !== {64'd25, 64'd17}) begin fails++; $display("FAIL wr_rd_b got=%h exp=%h", rd_b, {64'd25, 64'd17}); end
        checks++; if (rd_d !== {64'd25, 64'd17}) begin fails++; $display("FAIL wr_rd_d got=%h exp=%h", rd_d, {64'd25, 64'd17}); end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_sel = 5'd31; wr_data = 64'hDEAD_BEEF;
        rd_sel = {5'd31, 5'd31};
        #1;
        checks++; if (rd_a !== 128'd0) begin fails++; $display("FAIL zero_a_same got=%h exp=0", rd_a); end
        checks++; if (rd_b !== 128'd0) begin fails++; $display("FAIL zero_b_same got=%h exp=0", rd_b); end
        tick();
        wr_en = 1'b0;
        #1;
        checks++; if (rd_a !== 128'd0) begin fails++; $display("FAIL zero_a_next got=%h exp=0", rd_a); end
        checks++; if (rd_b !== {2{64'hDEAD_BEEF}}) begin fails++; $display("FAIL zero_b_next got=%h exp=%h", rd_b, {2{64'hDEAD_BEEF}}); end
        checks++; if (rd_d !== 128'd0) begin fails++; $display("FAIL zero_d_oor got=%h exp=0", rd_d); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_sel = 5'd7; wr_data = 64'd151;
        rd_sel = {5'd3, 5'd7};
        #1;
        checks++; if (rd_a !== {64'd17, 64'd151}) begin fails++; $display("FAIL bypass_a_same got=%h exp=%h", rd_a, {64'd17, 64'd151}); end
        checks++; if (rd_b !== {64'd17, 64'd0}) begin fails++; $display("FAIL nobypass_b_same got=%h exp=%h", rd_b, {64'd17, 64'd0}); end
        checks++; if (rd_d !== {64'd17, 64'd151}) begin fails++; $display("FAIL bypass_d_same got=%h exp=%h", rd_d, {64'd17, 64'd151}); end
        rd_sel = {5'd7, 5'd7};
        #1;
        checks++; if (rd_a !== {2{64'd151}}) begin fails++; $display("FAIL bypass_a_both got=%h exp=%h", rd_a, {2{64'd151}}); end
        tick();
        wr_en = 1'b0;
        #1;
        checks++; if (rd_b !== {2{64'd151}}) begin fails++; $display("FAIL nobypass_b_next got=%h exp=%h", rd_b, {2{64'd151}}); end
    endtask

    task automatic test_regread();
        rd_en = 2'b01; rd_sel = {5'd12, 5'd3};
        tick();
        checks++; if (vl_c !== 2'b01) begin fails++; $display("FAIL rr_valid_t1 got=%b exp=01", vl_c); end
        checks++; if (rd_c !== {64'd0, 64'd17}) begin fails++; $display("FAIL rr_data_t1 got=%h exp=%h", rd_c, {64'd0, 64'd17}); end
        rd_en = 2'b00; rd_sel = {5'd3, 5'd12};
        tick();
        checks++; if (vl_c !== 2'b00) begin fails++; $display("FAIL rr_valid_t2 got=%b exp=00", vl_c); end
        checks++; if (rd_c !== {64'd0, 64'd17}) begin fails++; $display("FAIL rr_hold_t2 got=%h exp=%h", rd_c, {64'd0, 64'd17}); end
        rd_en = 2'b11; rd_sel = {5'd12, 5'd7};
        tick();
        checks++; if (vl_c !== 2'b11 || rd_c !== {64'd25, 64'd151}) begin fails++; $display("FAIL rr_b2b_1 got=%b/%h exp=11/%h", vl_c, rd_c, {64'd25, 64'd151}); end
        rd_sel = {5'd3, 5'd12};
        tick();
        checks++; if (vl_c !== 2'b11 || rd_c !== {64'd17, 64'd25}) begin fails++; $display("FAIL rr_b2b_2 got=%b/%h exp=11/%h", vl_c, rd_c, {64'd17, 64'd25}); end
        rd_en = 2'b01; rd_sel = {5'd31, 5'd9};
        wr_en = 1'b1; wr_sel = 5'd9; wr_data = 64'd42;
        tick();
        wr_en = 1'b0; rd_en = 2'b00;
        checks++; if (vl_c !== 2'b01 || rd_c !== {64'd17, 64'd42}) begin fails++; $display("FAIL rr_bypass got=%b/%h exp=01/%h", vl_c, rd_c, {64'd17, 64'd42}); end
    endtask

    task automatic test_reset_midop();
        reset = 1'b1; wr_en = 1'b1; wr_sel = 5'd3; wr_data = 64'd99; rd_en = 2'b11;
        rd_sel = {5'd9, 5'd3};
        tick();
        reset = 1'b0; wr_en = 1'b0; rd_en = 2'b00;
        rd_sel = {5'd25, 5'd3};
        #1;
        checks++; if (rd_d !== 128'd0) begin fails++; $display("FAIL midrst_d got=%h exp=0", rd_d); end
        checks++; if (rd_a[63:0] !== 64'd0) begin fails++; $display("FAIL midrst_a_x3 got=%h exp=0", rd_a[63:0]); end
        checks++; if (vl_c !== 2'b00 || rd_c !== 128'd0) begin fails++; $display("FAIL midrst_c got=%b/%h exp=00/0", vl_c, rd_c); end
    endtask

    task automatic test_out_of_range();
        wr_en = 1'b1; wr_sel = 5'd25; wr_data = 64'd77;
        rd_sel = {5'd25, 5'd25};
        #1;
        checks++; if (rd_d !== 128'd0) begin fails++; $display("FAIL oor_d_same got=%h exp=0", rd_d); end
        tick();
        wr_sel = 5'd23; wr_data = 64'd5;
        #1;
        checks++; if (rd_d !== 128'd0) begin fails++; $display("FAIL oor_d_next got=%h exp=0", rd_d); end
        checks++; if (rd_a !== {2{64'd77}}) begin fails++; $display("FAIL oor_a_x25 got=%h exp=%h", rd_a, {2{64'd77}}); end
        tick();
        wr_en = 1'b0;
        rd_sel = {5'd23, 5'd23};
        #1;
        checks++; if (rd_d !== 128'd0) begin fails++; $display("FAIL zero_d_x23 got=%h exp=0", rd_d); end
        checks++; if (rd_a !== {2{64'd5}}) begin fails++; $display("FAIL last_a_x23 got=%h exp=%h", rd_a, {2{64'd5}}); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_regread();
        test_reset_midop();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
